// File: rtl/map_table_pkg.sv
// Shared rename-stage constants and tag types, common to map_table, arch_table,
// free list and ROB.
package map_table_pkg;

    localparam int unsigned WIDTH          = 2;
    localparam int unsigned PREG_NUMBER    = 64;
    localparam int unsigned ARCHREG_NUMBER = 32;
    localparam int unsigned PREG_W         = $clog2(PREG_NUMBER);
    localparam int unsigned AREG_W         = $clog2(ARCHREG_NUMBER);

    typedef logic [PREG_W-1:0] preg_tag_t;
    typedef logic [AREG_W-1:0] arch_reg_t;

endpackage

// File: rtl/map_table.sv
// Speculative register alias table: renames sources, reports ready bits and T_old,
// tracks CDB completions and restores from the committed map on recovery.
module map_table
    import map_table_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       rename_en_i,
    input  arch_reg_t              rename_dest_i        [WIDTH],
    input  preg_tag_t              rename_tag_i         [WIDTH],
    input  arch_reg_t              src1_arch_i          [WIDTH],
    input  arch_reg_t              src2_arch_i          [WIDTH],
    output preg_tag_t              src1_tag_o           [WIDTH],
    output preg_tag_t              src2_tag_o           [WIDTH],
    output logic [WIDTH-1:0]       src1_ready_o,
    output logic [WIDTH-1:0]       src2_ready_o,
    output preg_tag_t              told_o               [WIDTH],
    input  logic [WIDTH-1:0]       cdb_en_i,
    input  preg_tag_t              cdb_tag_i            [WIDTH],
    input  logic                   recover_i,
    input  preg_tag_t              arch_table_recover_i [ARCHREG_NUMBER]
);

    preg_tag_t                 map_q [ARCHREG_NUMBER];
    preg_tag_t                 map_d [ARCHREG_NUMBER];
    logic [ARCHREG_NUMBER-1:0] ready_q;
    logic [ARCHREG_NUMBER-1:0] ready_d;

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        arch_reg_t src   [2];
        preg_tag_t tag   [2];
        logic      rdy   [2];
        logic      fwd   [2];
        preg_tag_t told;

        assign src[0] = src1_arch_i[k];
        assign src[1] = src2_arch_i[k];

        always_comb begin
            for (int s = 0; s < 2; s++) begin
                tag[s] = map_q[src[s]];
                rdy[s] = ready_q[src[s]];
                fwd[s] = 1'b0;
                // Later lanes override earlier ones, so the highest matching lane wins.
                for (int j = 0; j < k; j++) begin
                    if (rename_en_i[j] && rename_dest_i[j] == src[s] && src[s] != '0) begin
                        tag[s] = rename_tag_i[j];
                        rdy[s] = 1'b0;
                        fwd[s] = 1'b1;
                    end
                end
                if (!fwd[s]) begin
                    for (int c = 0; c < WIDTH; c++) begin
                        if (cdb_en_i[c] && cdb_tag_i[c] == tag[s]) rdy[s] = 1'b1;
                    end
                end
                if (src[s] == '0) begin
                    tag[s] = '0;
                    rdy[s] = 1'b1;
                end
            end
        end

        always_comb begin
            told = map_q[rename_dest_i[k]];
            for (int j = 0; j < k; j++) begin
                if (rename_en_i[j] && rename_dest_i[j] == rename_dest_i[k] &&
                    rename_dest_i[k] != '0) begin
                    told = rename_tag_i[j];
                end
            end
        end

        assign src1_tag_o[k]   = tag[0];
        assign src2_tag_o[k]   = tag[1];
        assign src1_ready_o[k] = rdy[0];
        assign src2_ready_o[k] = rdy[1];
        assign told_o[k]       = told;
    end

    always_comb begin
        map_d   = map_q;
        ready_d = ready_q;
        if (recover_i) begin
            map_d   = arch_table_recover_i;
            ready_d = '1;
        end else begin
            for (int i = 0; i < ARCHREG_NUMBER; i++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    if (cdb_en_i[c] && map_q[i] == cdb_tag_i[c]) ready_d[i] = 1'b1;
                end
            end
            // Renames are applied after CDB sets so they take precedence on the same entry.
            for (int k = 0; k < WIDTH; k++) begin
                if (rename_en_i[k] && rename_dest_i[k] != '0) begin
                    map_d[rename_dest_i[k]]   = rename_tag_i[k];
                    ready_d[rename_dest_i[k]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCHREG_NUMBER; i++) map_q[i] <= preg_tag_t'(i);
            ready_q <= '1;
        end else begin
            map_q   <= map_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_map_table.sv
// Directed self-checking bench for map_table: reset, renaming, forwarding, CDB,
// recovery, r0 handling and asynchronous reset.
module tb_map_table;
    import map_table_pkg::*;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] rename_en;
    arch_reg_t        rename_dest [WIDTH];
    preg_tag_t        rename_tag  [WIDTH];
    arch_reg_t        src1_arch   [WIDTH];
    arch_reg_t        src2_arch   [WIDTH];
    preg_tag_t        src1_tag    [WIDTH];
    preg_tag_t        src2_tag    [WIDTH];
    logic [WIDTH-1:0] src1_ready;
    logic [WIDTH-1:0] src2_ready;
    preg_tag_t        told        [WIDTH];
    logic [WIDTH-1:0] cdb_en;
    preg_tag_t        cdb_tag     [WIDTH];
    logic             recover;
    preg_tag_t        recover_map [ARCHREG_NUMBER];

    int checks = 0;
    int errors = 0;

    map_table dut (
        .clk                  (clk),
        .reset                (reset),
        .rename_en_i          (rename_en),
        .rename_dest_i        (rename_dest),
        .rename_tag_i         (rename_tag),
        .src1_arch_i          (src1_arch),
        .src2_arch_i          (src2_arch),
        .src1_tag_o           (src1_tag),
        .src2_tag_o           (src2_tag),
        .src1_ready_o         (src1_ready),
        .src2_ready_o         (src2_ready),
        .told_o               (told),
        .cdb_en_i             (cdb_en),
        .cdb_tag_i            (cdb_tag),
        .recover_i            (recover),
        .arch_table_recover_i (recover_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running exp done");
        $fatal(1);
    end

    task automatic idle();
        rename_en = '0;
        cdb_en    = '0;
        recover   = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            rename_dest[k] = '0;
            rename_tag[k]  = '0;
            src1_arch[k]   = '0;
            src2_arch[k]   = '0;
            cdb_tag[k]     = '0;
        end
        for (int i = 0; i < ARCHREG_NUMBER; i++) recover_map[i] = preg_tag_t'(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        src1_arch[0] = 5'd3;  src1_arch[1] = 5'd5;
        src2_arch[0] = 5'd0;  src2_arch[1] = 5'd31;
        rename_en = 2'b11;
        rename_dest[0] = 5'd7; rename_dest[1] = 5'd9;
        rename_tag[0] = 6'd40; rename_tag[1] = 6'd41;
        #1;
        checks++; if (src1_tag[0] !== 6'd3) begin errors++; $display("FAIL reset_src1_l0: got %0d exp 3", src1_tag[0]); end
        checks++; if (src1_tag[1] !== 6'd5) begin errors++; $display("FAIL reset_src1_l1: got %0d exp 5", src1_tag[1]); end
        checks++; if (src1_ready !== 2'b11) begin errors++; $display("FAIL reset_src1_rdy: got %b exp 11", src1_ready); end
        checks++; if (src2_tag[1] !== 6'd31 || src2_tag[0] !== 6'd0) begin errors++; $display("FAIL reset_src2: got %0d,%0d exp 0,31", src2_tag[0], src2_tag[1]); end
        checks++; if (told[0] !== 6'd7 || told[1] !== 6'd9) begin errors++; $display("FAIL reset_told: got %0d,%0d exp 7,9", told[0], told[1]); end
        rename_en = '0;
        step();
    endtask

    task automatic test_same_dest();
        idle();
        rename_en = 2'b11;
        rename_dest[0] = 5'd7; rename_dest[1] = 5'd7;
        rename_tag[0] = 6'd40; rename_tag[1] = 6'd41;
        #1;
        checks++; if (told[0] !== 6'd7 || told[1] !== 6'd40) begin errors++; $display("FAIL same_dest_told: got %0d,%0d exp 7,40", told[0], told[1]); end
        step();
        idle();
        rename_en = 2'b01; rename_dest[0] = 5'd7;
        src1_arch[0] = 5'd7;
        #1;
        checks++; if (src1_tag[0] !== 6'd41) begin errors++; $display("FAIL same_dest_map: got %0d exp 41", src1_tag[0]); end
        checks++; if (src1_ready[0] !== 1'b0) begin errors++; $display("FAIL same_dest_rdy: got %b exp 0", src1_ready[0]); end
        checks++; if (told[0] !== 6'd41) begin errors++; $display("FAIL same_dest_told2: got %0d exp 41", told[0]); end
        rename_en = '0;
        step();
    endtask

    task automatic test_intra_group();
        idle();
        rename_en = 2'b01; rename_dest[0] = 5'd4; rename_tag[0] = 6'd33;
        src1_arch[0] = 5'd4; src1_arch[1] = 5'd4;
        #1;
        checks++; if (src1_tag[1] !== 6'd33 || src1_ready[1] !== 1'b0) begin errors++; $display("FAIL intra_fwd: got %0d/%b exp 33/0", src1_tag[1], src1_ready[1]); end
        checks++; if (src1_tag[0] !== 6'd4 || src1_ready[0] !== 1'b1) begin errors++; $display("FAIL intra_own: got %0d/%b exp 4/1", src1_tag[0], src1_ready[0]); end
        step();
    endtask

    task automatic test_cdb();
        idle();
        rename_en = 2'b01; rename_dest[0] = 5'd10; rename_tag[0] = 6'd50;
        step();
        idle();
        src1_arch[0] = 5'd10;
        #1;
        checks++; if (src1_tag[0] !== 6'd50 || src1_ready[0] !== 1'b0) begin errors++; $display("FAIL cdb_pre: got %0d/%b exp 50/0", src1_tag[0], src1_ready[0]); end
        cdb_en = 2'b11; cdb_tag[0] = 6'd50; cdb_tag[1] = 6'd50;
        #1;
        checks++; if (src1_ready[0] !== 1'b1) begin errors++; $display("FAIL cdb_bypass: got %b exp 1", src1_ready[0]); end
        step();
        idle();
        src1_arch[0] = 5'd10;
        #1;
        checks++; if (src1_tag[0] !== 6'd50 || src1_ready[0] !== 1'b1) begin errors++; $display("FAIL cdb_write: got %0d/%b exp 50/1", src1_tag[0], src1_ready[0]); end
        // rename and completion of the old tag in the same cycle
        rename_en = 2'b01; rename_dest[0] = 5'd10; rename_tag[0] = 6'd51;
        cdb_en = 2'b01; cdb_tag[0] = 6'd50;
        step();
        idle();
        src1_arch[0] = 5'd10;
        #1;
        checks++; if (src1_tag[0] !== 6'd51 || src1_ready[0] !== 1'b0) begin errors++; $display("FAIL cdb_precedence: got %0d/%b exp 51/0", src1_tag[0], src1_ready[0]); end
        idle();
        rename_en = 2'b01; rename_dest[0] = 5'd12; rename_tag[0] = 6'd45;
        src2_arch[1] = 5'd12; src2_arch[0] = 5'd7;
        cdb_en = 2'b11; cdb_tag[0] = 6'd45; cdb_tag[1] = 6'd41;
        #1;
        checks++; if (src2_tag[1] !== 6'd45 || src2_ready[1] !== 1'b0) begin errors++; $display("FAIL cdb_no_fwd_bypass: got %0d/%b exp 45/0", src2_tag[1], src2_ready[1]); end
        checks++; if (src2_tag[0] !== 6'd41 || src2_ready[0] !== 1'b1) begin errors++; $display("FAIL cdb_lane1_bypass: got %0d/%b exp 41/1", src2_tag[0], src2_ready[0]); end
        step();
        idle();
        cdb_en = 2'b10; cdb_tag[1] = 6'd63;
        step();
        idle();
        src1_arch[0] = 5'd10; src1_arch[1] = 5'd7; src2_arch[0] = 5'd12;
        #1;
        checks++; if (src1_tag[0] !== 6'd51 || src1_ready[0] !== 1'b0) begin errors++; $display("FAIL cdb_absent_tag: got %0d/%b exp 51/0", src1_tag[0], src1_ready[0]); end
        checks++; if (src1_tag[1] !== 6'd41 || src1_ready[1] !== 1'b1) begin errors++; $display("FAIL cdb_lane1_write: got %0d/%b exp 41/1", src1_tag[1], src1_ready[1]); end
        checks++; if (src2_tag[0] !== 6'd45 || src2_ready[0] !== 1'b0) begin errors++; $display("FAIL cdb_renamed_entry: got %0d/%b exp 45/0", src2_tag[0], src2_ready[0]); end
    endtask

    task automatic test_recover();
        idle();
        rename_en = 2'b11;
        rename_dest[0] = 5'd2; rename_dest[1] = 5'd3;
        rename_tag[0] = 6'd20; rename_tag[1] = 6'd21;
        step();
        idle();
        recover_map[2] = 6'd60;
        recover = 1'b1;
        rename_en = 2'b11;
        rename_dest[0] = 5'd5; rename_dest[1] = 5'd6;
        rename_tag[0] = 6'd22; rename_tag[1] = 6'd23;
        cdb_en = 2'b01; cdb_tag[0] = 6'd7;
        step();
        idle();
        src1_arch[0] = 5'd2; src1_arch[1] = 5'd7;
        src2_arch[0] = 5'd3; src2_arch[1] = 5'd5;
        #1;
        checks++; if (src1_tag[0] !== 6'd60 || src1_tag[1] !== 6'd7) begin errors++; $display("FAIL recover_src1: got %0d,%0d exp 60,7", src1_tag[0], src1_tag[1]); end
        checks++; if (src1_ready !== 2'b11) begin errors++; $display("FAIL recover_rdy1: got %b exp 11", src1_ready); end
        checks++; if (src2_tag[0] !== 6'd3 || src2_tag[1] !== 6'd5) begin errors++; $display("FAIL recover_src2: got %0d,%0d exp 3,5", src2_tag[0], src2_tag[1]); end
        checks++; if (src2_ready !== 2'b11) begin errors++; $display("FAIL recover_rdy2: got %b exp 11", src2_ready); end
    endtask

    task automatic test_r0();
        idle();
        rename_en = 2'b11;
        rename_dest[0] = 5'd0; rename_dest[1] = 5'd0;
        rename_tag[0] = 6'd11; rename_tag[1] = 6'd12;
        src1_arch[1] = 5'd0;
        #1;
        checks++; if (src1_tag[1] !== 6'd0 || src1_ready[1] !== 1'b1) begin errors++; $display("FAIL r0_no_fwd: got %0d/%b exp 0/1", src1_tag[1], src1_ready[1]); end
        step();
        idle();
        #1;
        checks++; if (src1_tag[0] !== 6'd0 || src1_ready[0] !== 1'b1) begin errors++; $display("FAIL r0_write: got %0d/%b exp 0/1", src1_tag[0], src1_ready[0]); end
    endtask

    task automatic test_async_reset();
        idle();
        rename_en = 2'b01; rename_dest[0] = 5'd8; rename_tag[0] = 6'd30;
        step();
        idle();
        src1_arch[0] = 5'd8;
        #1;
        checks++; if (src1_tag[0] !== 6'd30 || src1_ready[0] !== 1'b0) begin errors++; $display("FAIL async_pre: got %0d/%b exp 30/0", src1_tag[0], src1_ready[0]); end
        reset = 1'b1;
        #1;
        checks++; if (src1_tag[0] !== 6'd8 || src1_ready[0] !== 1'b1) begin errors++; $display("FAIL async_reset: got %0d/%b exp 8/1", src1_tag[0], src1_ready[0]); end
        // reset held across a recover edge must still leave the identity map
        recover_map[2] = 6'd60;
        recover = 1'b1;
        step();
        reset = 1'b0;
        idle();
        src1_arch[0] = 5'd2;
        #1;
        checks++; if (src1_tag[0] !== 6'd2 || src1_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_over_recover: got %0d/%b exp 2/1", src1_tag[0], src1_ready[0]); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_same_dest();
        test_intra_group();
        test_cdb();
        test_recover();
        test_r0();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
